// File: rtl/drum_spi_pkg.sv
// Shared types and constants for the MCU drum-command SPI transmitter.
// DRUM_TX_PARITY_EN adds an odd-parity bit after the 8 data bits.
package drum_spi_pkg;

  localparam int CMD_W = 8;

`ifdef DRUM_TX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [CMD_W-1:0] {
    KICK  = 8'h02,
    SNARE = 8'h05,
    HIHAT = 8'h09,
    TOM   = 8'h0C,
    CRASH = 8'h10
  } drum_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD,
    ACK
  } tx_state_t;

endpackage

// File: rtl/async_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input, followed by a
// single-cycle rise/fall edge detector in the clk domain.
module async_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour and the chain cannot collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/drum_cmd_spi_tx.sv
// Queued drum-command transmitter: shifts each byte MSB-first on mcu_sdo
// under the MCU's mcu_sck and pops the next one after a mcu_load ack.
// DRUM_TX_PARITY_EN appends an odd-parity bit to each frame.
module drum_cmd_spi_tx
  import drum_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  input  logic [CMD_W-1:0]              cmd_data,
  output logic                          cmd_ready,
  input  logic                          mcu_sck,
  input  logic                          mcu_load,
  output logic                          mcu_sdo,
  output logic                          mcu_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic sck_fall, sck_rise_unused, load_rise, load_fall;

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mcu_sck),
    .rise     (sck_rise_unused),
    .fall     (sck_fall)
  );

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mcu_load),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  // Command queue: circular buffer, extra pointer bit distinguishes full from empty.
  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             empty, full, push, pop;
  logic [CMD_W-1:0] head;
  tx_state_t        state_q, state_d;

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = (state_q == LOAD);
  assign cmd_ready  = !full || pop;
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = wptr_q - rptr_q;
  assign head       = mem[rptr_q[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      overflow <= cmd_valid && !cmd_ready;
    end
  end

  logic [FRAME_BITS-1:0] frame_word, shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

`ifdef DRUM_TX_PARITY_EN
  assign frame_word = {head, ~^head};
`else
  assign frame_word = head;
`endif

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (!empty) state_d = LOAD;
      LOAD: begin
        shift_d = frame_word;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // An ack outranks a simultaneous sck edge and abandons the frame.
        if (load_rise) begin
          state_d = ACK;
        end else if (sck_fall) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = HOLD;
        end
      end
      HOLD:  if (load_rise) state_d = ACK;
      ACK:   if (load_fall) state_d = empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      mcu_done <= 1'b0;
      mcu_sdo  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      mcu_done <= (state_q == SHIFT) || (state_q == HOLD);
      mcu_sdo  <= (state_q == SHIFT) && shift_q[FRAME_BITS-1];
    end
  end

endmodule

// File: tb/tb_drum_cmd_spi_tx.sv
// Directed self-checking bench for drum_cmd_spi_tx; an MCU model clocks
// frames out with mcu_sck and acknowledges them with mcu_load.
module tb_drum_cmd_spi_tx;

`ifdef DRUM_TX_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       mcu_sck = 1'b0;
  logic       mcu_load = 1'b0;
  logic       mcu_sdo, mcu_done, overflow;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  drum_cmd_spi_tx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .mcu_sck    (mcu_sck),
    .mcu_load   (mcu_load),
    .mcu_sdo    (mcu_sdo),
    .mcu_done   (mcu_done),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!mcu_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(mcu_done), 32'd1);
  endtask

  // MCU samples sdo just before each falling edge of sck.
  task automatic mcu_read(input int n, output logic [15:0] data);
    data = '0;
    for (int i = 0; i < n; i++) begin
      mcu_sck = 1'b1;
      repeat (4) @(negedge clk);
      data = {data[14:0], mcu_sdo};
      mcu_sck = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [15:0] w;
    mcu_read(FB, w);
    b = w[FB-1 -: 8];
  endtask

  task automatic mcu_ack(input string tag);
    mcu_load = 1'b1;
    repeat (5) @(negedge clk);
    check(tag, 32'(mcu_done), 32'd0);
    mcu_load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  b;
    logic [7:0]  exp_kick;
    logic [7:0]  fill [5];

    exp_kick = 8'h02;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done", 32'(mcu_done), 32'd0);
    check("rst_sdo", 32'(mcu_sdo), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single KICK, done latency, bit-by-bit, HOLD after the frame
    push(8'h02);
    @(negedge clk);
    @(negedge clk);
    check("t1_done_edge2", 32'(mcu_done), 32'd0);
    @(negedge clk);
    check("t1_done_edge3", 32'(mcu_done), 32'd1);
    for (int i = 0; i < 8; i++) begin
      mcu_sck = 1'b1;
      repeat (4) @(negedge clk);
      check($sformatf("t1_bit%0d", i), 32'(mcu_sdo), 32'(exp_kick[7-i]));
      mcu_sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    mcu_read(1, w);
    check("t1_bit8", 32'(w[0]), 32'd0);
    mcu_read(1, w);
    check("t1_hold_sdo", 32'(mcu_sdo), 32'd0);
    check("t1_hold_done", 32'(mcu_done), 32'd1);
    mcu_ack("t1_ack_done");
    repeat (10) @(negedge clk);
    check("t1_idle_done", 32'(mcu_done), 32'd0);

    // 2: three back-to-back commands
    push(8'h02);
    push(8'h05);
    push(8'h09);
    wait_done("t2_done0");
    check("t2_count2", 32'(fifo_count), 32'd2);
    read_byte(b);
    check("t2_byte0", 32'(b), 32'h02);
    mcu_ack("t2_ack0");
    wait_done("t2_done1");
    check("t2_count1", 32'(fifo_count), 32'd1);
    read_byte(b);
    check("t2_byte1", 32'(b), 32'h05);
    mcu_ack("t2_ack1");
    wait_done("t2_done2");
    check("t2_count0", 32'(fifo_count), 32'd0);
    read_byte(b);
    check("t2_byte2", 32'(b), 32'h09);
    mcu_ack("t2_ack2");
    repeat (10) @(negedge clk);
    check("t2_idle_done", 32'(mcu_done), 32'd0);

    // 3: full queue plus one in shift, then an extra push is dropped
    push(fill[0]);
    wait_done("t3_done_first");
    for (int i = 1; i < 5; i++) push(fill[i]);
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_ready_low", 32'(cmd_ready), 32'd0);
    push(8'h66);
    check("t3_ovf_pulse", 32'(overflow), 32'd1);
    @(negedge clk);
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    check("t3_count_kept", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_done($sformatf("t3_done%0d", i));
      read_byte(b);
      check($sformatf("t3_byte%0d", i), 32'(b), 32'(fill[i]));
      mcu_ack($sformatf("t3_ack%0d", i));
    end
    repeat (10) @(negedge clk);
    check("t3_no_extra", 32'(mcu_done), 32'd0);
    check("t3_count_end", 32'(fifo_count), 32'd0);

    // 4: early ack after three bits abandons A5, next byte goes out whole
    push(8'hA5);
    push(8'h3C);
    wait_done("t4_done0");
    mcu_read(3, w);
    check("t4_partial", 32'(w[2:0]), 32'b101);
    mcu_ack("t4_early_ack");
    wait_done("t4_done1");
    read_byte(b);
    check("t4_next_byte", 32'(b), 32'h3C);
    mcu_ack("t4_ack1");
    repeat (10) @(negedge clk);
    check("t4_idle_done", 32'(mcu_done), 32'd0);

    // 6: parity frame (or plain 8-bit frame with HOLD afterwards)
    push(8'h03);
    wait_done("t6_done");
`ifdef DRUM_TX_PARITY_EN
    mcu_read(9, w);
    check("t6_frame9", 32'(w[8:0]), 32'h007);
`else
    mcu_read(8, w);
    check("t6_frame8", 32'(w[7:0]), 32'h03);
    mcu_read(1, w);
    check("t6_bit9", 32'(w[0]), 32'd0);
`endif
    check("t6_hold_done", 32'(mcu_done), 32'd1);
    mcu_ack("t6_ack");

    // 5: asynchronous reset mid-SHIFT
    push(8'hA5);
    push(8'h5A);
    wait_done("t5_done");
    check("t5_sdo_msb", 32'(mcu_sdo), 32'd1);
    check("t5_count1", 32'(fifo_count), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_done", 32'(mcu_done), 32'd0);
    check("t5_rst_sdo", 32'(mcu_sdo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_count_after", 32'(fifo_count), 32'd0);
    check("t5_ready_after", 32'(cmd_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("t5_lost_queue", 32'(mcu_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
